// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register bank:
// default geometry, bank state encoding and flat-bus slicing helper.
package regfile_pkg;

  localparam int RF_XLEN_DEF  = 64;
  localparam int RF_NREGS_DEF = 32;
  localparam int RF_NRD_DEF   = 2;
  localparam int RF_NWR_DEF   = 2;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Low bit index of port 'port' inside a flat bus of 'width'-bit lanes.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/write-back facing bus of the register bank.
// master: decode + write-back side; slave: the bank itself.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF,
  parameter int NWR   = RF_NWR_DEF
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                ready;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight results. Writes release, a claim
// sets; a claim beats a release of the same register in the same cycle.
// x0 is never busy. Everything is held clear while the bank is sweeping.
// With REGFILE_BYPASS_EN defined, a read hitting a same-cycle write sees
// the post-write busy state (busy only if the same register is claimed).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF,
  parameter int NWR   = RF_NWR_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: releases first, then the claim so it takes priority.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) begin
          busy_d[wr_addr[slice_lo(w, AW) +: AW]] = 1'b0;
        end
      end
      if (claim_en) begin
        busy_d[claim_addr] = 1'b1;
      end
    end else begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
    if (rst) begin
      busy_d = '0;
    end
  end

  // Busy register.
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic          claim_hit;

    assign ra        = rd_addr[p*AW +: AW];
    assign claim_hit = claim_en && (claim_addr == ra);

    // Detect a same-cycle write to this read address (bypass builds only).
    always_comb begin
      hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[slice_lo(w, AW) +: AW] == ra)) begin
          hit = 1'b1;
        end
      end
`endif
    end

    assign rd_busy[p] = run && (ra != '0) && (hit ? claim_hit : busy_q[ra]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register bank: NRD combinational read ports, NWR
// write ports (highest port wins on address collisions), x0 hardwired to
// zero, busy scoreboard, and a one-register-per-cycle clear sweep after
// reset during which all traffic is ignored and reads return zero.
// Optional: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NRD   = RF_NRD_DEF,
  parameter int NWR   = RF_NWR_DEF
) (
  input logic       clk,
  input logic       rst,
  regfile_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            run;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  assign run       = (state_q == RF_RUN);
  assign bus.ready = ready_q;

  // Bank control: sweep index walks every register once, then RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    case (state_q)
      RF_CLEAR: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: begin
        state_d = RF_RUN;
      end
      default: begin
        state_d = RF_CLEAR;
      end
    endcase
    if (rst) begin
      state_d = RF_CLEAR;
      idx_d   = '0;
      ready_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    idx_q   <= idx_d;
    ready_q <= ready_d;
  end

  // Storage update: zero the swept register, or apply writes in port order
  // so the highest port lands last; x0 is never written with data.
  always_comb begin
    regs_d = regs_q;
    if (state_q == RF_CLEAR) begin
      regs_d[idx_q] = '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[slice_lo(w, AW) +: AW] != '0)) begin
          regs_d[bus.wr_addr[slice_lo(w, AW) +: AW]] =
            bus.wr_data[slice_lo(w, XLEN) +: XLEN];
        end
      end
    end
  end

  // Register storage (data only, cleared by the sweep rather than by rst).
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = bus.rd_addr[p*AW +: AW];

    // Read value: stored word, overridden by the highest same-cycle write.
    always_comb begin
      rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w] && (bus.wr_addr[slice_lo(w, AW) +: AW] == ra)) begin
          rv = bus.wr_data[slice_lo(w, XLEN) +: XLEN];
        end
      end
`endif
    end

    assign bus.rd_data[p*XLEN +: XLEN] = (run && (ra != '0)) ? rv : '0;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .claim_en   (bus.claim_en),
    .claim_addr (bus.claim_addr),
    .rd_addr    (bus.rd_addr),
    .rd_busy    (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver applies one stimulus set per
// cycle and pushes the reference model's expected read-side outputs; a
// monitor pops and compares on the falling edge.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  typedef struct packed {
    logic                ready;
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus for the next cycle
  logic            t_rst;
  logic [AW-1:0]   t_rd_addr [NRD];
  logic            t_wr_en   [NWR];
  logic [AW-1:0]   t_wr_addr [NWR];
  logic [XLEN-1:0] t_wr_data [NWR];
  logic            t_claim_en;
  logic [AW-1:0]   t_claim_addr;

  // reference model
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];
  int              m_since_rst;
  bit              m_ready;

  exp_t exp_q[$];
  bit   started = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: the bank becomes usable NREGS cycles after reset is released,
  // at which point every register reads zero; afterwards writes land in
  // port order and a claim is applied after the releases.
  task automatic model_edge();
    if (rst) begin
      m_since_rst = 0;
      m_ready = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_since_rst++;
      if (m_since_rst >= NREGS) begin
        m_ready = 1;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        logic [AW-1:0] wa;
        wa = bus.wr_addr[w*AW +: AW];
        if (bus.wr_en[w] && wa != 0) begin
          m_mem[wa]  = bus.wr_data[w*XLEN +: XLEN];
          m_busy[wa] = 0;
        end
      end
      if (bus.claim_en && bus.claim_addr != 0) m_busy[bus.claim_addr] = 1;
    end
  endtask

  function automatic exp_t model_reads();
    exp_t e;
    e.ready = m_ready;
    e.data  = '0;
    e.busy  = '0;
    if (m_ready) begin
      for (int p = 0; p < NRD; p++) begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        a = t_rd_addr[p];
        d = '0;
        b = 1'b0;
        if (a != 0) begin
          d = m_mem[a];
          b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
          for (int w = 0; w < NWR; w++) begin
            if (t_wr_en[w] && t_wr_addr[w] == a) begin
              d = t_wr_data[w];
              b = t_claim_en && (t_claim_addr == a);
            end
          end
`endif
        end
        e.data[p*XLEN +: XLEN] = d;
        e.busy[p] = b;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    rst = t_rst;
    for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = t_rd_addr[p];
    for (int w = 0; w < NWR; w++) begin
      bus.wr_en[w] = t_wr_en[w];
      bus.wr_addr[w*AW +: AW] = t_wr_addr[w];
      bus.wr_data[w*XLEN +: XLEN] = t_wr_data[w];
    end
    bus.claim_en   = t_claim_en;
    bus.claim_addr = t_claim_addr;
    exp_q.push_back(model_reads());
    started = 1;
  endtask

  task automatic quiet();
    t_rst = 0;
    t_claim_en = 0;
    t_claim_addr = '0;
    for (int w = 0; w < NWR; w++) begin
      t_wr_en[w] = 0;
      t_wr_addr[w] = '0;
      t_wr_data[w] = '0;
    end
  endtask

  task automatic rand_stim(input bit narrow);
    for (int p = 0; p < NRD; p++)
      t_rd_addr[p] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    for (int w = 0; w < NWR; w++) begin
      t_wr_en[w]   = ($urandom_range(0, 1) == 1);
      t_wr_addr[w] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      t_wr_data[w] = {$urandom, $urandom};
    end
    t_claim_en   = ($urandom_range(0, 2) == 0);
    t_claim_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
  endtask

  task automatic run_steps(input int n, input bit randomize_traffic);
    for (int i = 0; i < n; i++) begin
      if (randomize_traffic) rand_stim(1'b0);
      step();
    end
  endtask

  // Monitor: every falling edge the DUT read side is compared to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        if (exp_q.size() == 0) begin
          check("queue_empty", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("ready", {63'd0, bus.ready}, {63'd0, e.ready});
          for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data%0d", p), bus.rd_data[p*XLEN +: XLEN], e.data[p*XLEN +: XLEN]);
            check($sformatf("rd_busy%0d", p), {63'd0, bus.rd_busy[p]}, {63'd0, e.busy[p]});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rd_addr = '0; bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.claim_en = 1'b0; bus.claim_addr = '0;
    foreach (m_mem[i]) m_mem[i] = '0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_since_rst = 0;
    m_ready = 0;
    quiet();
    for (int p = 0; p < NRD; p++) t_rd_addr[p] = '0;

    // reset one cycle, then the sweep with random (ignored) traffic
    t_rst = 1; step();
    t_rst = 0;
    run_steps(NREGS + 2, 1'b1);
    quiet();

    // colliding writes to x5: port 1 wins
    t_wr_en[0] = 1; t_wr_addr[0] = 5; t_wr_data[0] = 64'hDEAD;
    t_wr_en[1] = 1; t_wr_addr[1] = 5; t_wr_data[1] = 64'hBEEF;
    t_rd_addr[0] = 5; t_rd_addr[1] = 5;
    step(); quiet(); step();

    // x0 ignores writes and claims
    t_wr_en[0] = 1; t_wr_addr[0] = 0; t_wr_data[0] = 64'h1234;
    t_claim_en = 1; t_claim_addr = 0;
    t_rd_addr[0] = 0; t_rd_addr[1] = 0;
    step(); quiet(); step();

    // claim / release / claim-beats-release on x7
    t_rd_addr[0] = 7; t_rd_addr[1] = 7;
    t_claim_en = 1; t_claim_addr = 7; step(); quiet(); step();
    t_wr_en[0] = 1; t_wr_addr[0] = 7; t_wr_data[0] = 64'd9; step(); quiet(); step();
    t_claim_en = 1; t_claim_addr = 7;
    t_wr_en[1] = 1; t_wr_addr[1] = 7; t_wr_data[1] = 64'd11; step(); quiet(); step();

    // write and read x3 in the same cycle
    t_rd_addr[0] = 3; t_rd_addr[1] = 5;
    t_wr_en[0] = 1; t_wr_addr[0] = 3; t_wr_data[0] = 64'h55;
    step(); quiet(); step();

    // reset in the middle of the sweep restarts it
    t_rst = 1; step();
    t_rst = 0; run_steps(10, 1'b1);
    quiet(); t_rst = 1; step();
    t_rst = 0; run_steps(NREGS + 2, 1'b1);
    quiet();

    // random traffic, mostly on a few registers to force collisions
    for (int i = 0; i < 2000; i++) begin
      rand_stim($urandom_range(0, 3) != 0);
      t_rst = ($urandom_range(0, 299) == 0);
      step();
    end
    quiet();
    step();

    @(negedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
